// File: rtl/stopwatch_lap.sv
// stopwatch_lap: prescaled BCD stopwatch with a small lap buffer and recall
// browsing. Live time and the selected lap drive one FND 7-segment decoder
// per digit.
// Optional feature: define LAP_OVERWRITE_EN so that a record on a full
// buffer overwrites the oldest lap instead of being ignored.

`default_nettype none

module stopwatch_lap #(
  parameter  int TICK_DIV  = 5_000_000,
  parameter  int NUM_DIG   = 3,
  parameter  int LAP_DEPTH = 4,
  localparam int LW        = $clog2(LAP_DEPTH)
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic                 i_fStart,
  input  logic                 i_fStop,
  input  logic                 i_fRecord,
  input  logic                 i_fRecall,
  output logic [7*NUM_DIG-1:0] o_Live,
  output logic [7*NUM_DIG-1:0] o_Lap,
  output logic [LW-1:0]        o_LapIdx,
  output logic [LW:0]          o_LapCnt,
  output logic                 o_fFull,
  output logic                 o_fOvf,
  output logic [1:0]           o_State
);

`ifdef LAP_OVERWRITE_EN
  localparam bit OVERWRITE = 1'b1;
`else
  localparam bit OVERWRITE = 1'b0;
`endif

  localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_END = PW'(TICK_DIV - 1);
  localparam logic [LW-1:0] LAST    = LW'(LAP_DEPTH - 1);
  localparam logic [LW:0]   DEPTH_C = (LW + 1)'(LAP_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  state_t state, state_nx;
  logic   running, armed;

  // Buttons, bit order: 0 start, 1 stop, 2 record, 3 recall (all active-low)
  logic [3:0] btn_raw, sync1, sync2, hist, press;
  logic       start_p, stop_p, rec_p, recall_p;

  logic [PW-1:0] presc;
  logic          tick;

  logic [3:0]           digit [NUM_DIG];
  logic [NUM_DIG:0]     carry;
  logic [4*NUM_DIG-1:0] snap;
  logic                 ovf;

  logic [4*NUM_DIG-1:0] lap_mem [LAP_DEPTH];
  logic [4*NUM_DIG-1:0] lap_view;
  logic [LW-1:0]        wr, rd, wr_next, rd_next;
  logic [LW:0]          cnt;
  logic                 full, rec_ok, recall_ok;

  assign btn_raw  = {i_fRecall, i_fRecord, i_fStop, i_fStart};
  assign press    = ~sync2 & hist;
  assign start_p  = press[0];
  assign stop_p   = press[1];
  assign rec_p    = press[2];
  assign recall_p = press[3];

  // Two-flop synchroniser plus history flop; reset to released so no false press
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync1 <= '1;
      sync2 <= '1;
      hist  <= '1;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  // FSM state register
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) state <= IDLE;
    else       state <= state_nx;
  end

  // FSM next state: stop always returns to IDLE and wins over start
  always_comb begin
    state_nx = state;
    if (stop_p) begin
      state_nx = IDLE;
    end else if (start_p) begin
      case (state)
        IDLE:    state_nx = RUN;
        RUN:     state_nx = PAUSE;
        PAUSE:   state_nx = RUN;
        default: state_nx = IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    o_State = state;
    running = (state == RUN);
    armed   = (state != IDLE);
  end

  assign tick = running && (presc == PRE_END);

  // Prescaler advances only while running and wraps after each tick
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst)        presc <= '0;
    else if (stop_p)  presc <= '0;
    else if (running) presc <= (presc == PRE_END) ? '0 : presc + 1'b1;
  end

  // Carry chain: carry[k] is high when every digit below k reads 9
  always_comb begin
    logic all_nine;
    all_nine = 1'b1;
    snap     = '0;
    carry    = '0;
    for (int k = 0; k < NUM_DIG; k++) begin
      carry[k]         = all_nine;
      all_nine         = all_nine && (digit[k] == 4'd9);
      snap[4*k +: 4]   = digit[k];
    end
    carry[NUM_DIG] = all_nine;
  end

  // BCD digit cascade, cleared whenever the FSM enters IDLE
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      for (int k = 0; k < NUM_DIG; k++) digit[k] <= 4'd0;
    end else if (stop_p) begin
      for (int k = 0; k < NUM_DIG; k++) digit[k] <= 4'd0;
    end else if (tick) begin
      for (int k = 0; k < NUM_DIG; k++) begin
        if (carry[k]) digit[k] <= (digit[k] == 4'd9) ? 4'd0 : digit[k] + 4'd1;
      end
    end
  end

  // Sticky wrap flag, set when the whole counter rolls over
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst)                        ovf <= 1'b0;
    else if (stop_p)                  ovf <= 1'b0;
    else if (tick && carry[NUM_DIG])  ovf <= 1'b1;
  end

  assign full      = (cnt == DEPTH_C);
  assign rec_ok    = rec_p && !stop_p && armed && (!full || OVERWRITE);
  assign recall_ok = recall_p && !rec_ok && (cnt != '0);
  assign wr_next   = (wr == LAST) ? '0 : wr + 1'b1;
  assign rd_next   = (({1'b0, rd} + (LW + 1)'(1)) == cnt) ? '0 : rd + 1'b1;

  // Lap buffer: record captures the pre-tick digits and points the reader at it
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      for (int i = 0; i < LAP_DEPTH; i++) lap_mem[i] <= '0;
      wr  <= '0;
      rd  <= '0;
      cnt <= '0;
    end else if (stop_p) begin
      for (int i = 0; i < LAP_DEPTH; i++) lap_mem[i] <= '0;
      wr  <= '0;
      rd  <= '0;
      cnt <= '0;
    end else if (rec_ok) begin
      lap_mem[wr] <= snap;
      wr          <= wr_next;
      rd          <= wr;
      if (!full) cnt <= cnt + 1'b1;
    end else if (recall_ok) begin
      rd <= rd_next;
    end
  end

  // Registered lap view follows the read pointer one edge later
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst)            lap_view <= '0;
    else if (cnt == '0)   lap_view <= '0;
    else                  lap_view <= lap_mem[rd];
  end

  assign o_LapIdx = rd;
  assign o_LapCnt = cnt;
  assign o_fFull  = full;
  assign o_fOvf   = ovf;

  for (genvar k = 0; k < NUM_DIG; k++) begin : g_dig
    fnd u_live (.bcd(digit[k]),            .seg(o_Live[7*k +: 7]));
    fnd u_lap  (.bcd(lap_view[4*k +: 4]),  .seg(o_Lap[7*k +: 7]));
  end

endmodule

// fnd: BCD to 7-segment decoder, segments {g,f,e,d,c,b,a}, active high
module fnd (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Lookup of the segment pattern; non-BCD codes blank the digit
  always_comb begin
    case (bcd)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_lap.sv
// tb_stopwatch_lap: directed and randomized checks of stopwatch_lap against a
// time-count reference model (elapsed run cycles, lap queue).

module tb_stopwatch_lap;

  localparam int TICK_DIV  = 4;
  localparam int NUM_DIG   = 2;
  localparam int LAP_DEPTH = 2;
  localparam int LW        = $clog2(LAP_DEPTH);
  localparam int MODV      = 100;

`ifdef LAP_OVERWRITE_EN
  localparam bit OVW = 1'b1;
`else
  localparam bit OVW = 1'b0;
`endif

  localparam logic [3:0] B_START  = 4'b0001;
  localparam logic [3:0] B_STOP   = 4'b0010;
  localparam logic [3:0] B_REC    = 4'b0100;
  localparam logic [3:0] B_RECALL = 4'b1000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic f_start = 1'b1, f_stop = 1'b1, f_record = 1'b1, f_recall = 1'b1;

  logic [7*NUM_DIG-1:0] live, lap;
  logic [LW-1:0]        lap_idx;
  logic [LW:0]          lap_cnt;
  logic                 full, ovf;
  logic [1:0]           state;

  int checks = 0;
  int errors = 0;

  // Reference model: time is elapsed RUN cycles since the last clear
  int       m_state    = 0;
  int       m_run      = 0;
  int       m_total    = 0;
  int       m_sel      = 0;
  int       m_lap_disp = 0;
  int       laps[$];
  bit [3:0] s0 = 4'hF, s1 = 4'hF, s2 = 4'hF;
  bit [3:0] pulse;
  int       n_laps, val_pre;
  bit       was_run, rec_ok;

  stopwatch_lap #(
    .TICK_DIV (TICK_DIV),
    .NUM_DIG  (NUM_DIG),
    .LAP_DEPTH(LAP_DEPTH)
  ) dut (
    .i_Clk    (clk),
    .i_Rst    (rst),
    .i_fStart (f_start),
    .i_fStop  (f_stop),
    .i_fRecord(f_record),
    .i_fRecall(f_recall),
    .o_Live   (live),
    .o_Lap    (lap),
    .o_LapIdx (lap_idx),
    .o_LapCnt (lap_cnt),
    .o_fFull  (full),
    .o_fOvf   (ovf),
    .o_State  (state)
  );

  always #5 clk = ~clk;

  // Model update per clock edge; a press acts three edges after the input falls
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_run = 0; m_total = 0; m_sel = 0; m_lap_disp = 0;
      laps.delete();
      s0 = 4'hF; s1 = 4'hF; s2 = 4'hF;
    end else begin
      pulse   = ~s1 & s2;
      s2      = s1;
      s1      = s0;
      s0      = {f_recall, f_record, f_stop, f_start};
      n_laps  = laps.size();
      val_pre = (m_run / TICK_DIV) % MODV;
      m_lap_disp = (n_laps == 0) ? 0 : laps[m_sel];
      if (pulse[1]) begin
        m_state = 0; m_run = 0; m_total = 0; m_sel = 0;
        laps.delete();
      end else begin
        was_run = (m_state == 1);
        rec_ok  = pulse[2] && (m_state != 0) && ((n_laps < LAP_DEPTH) || OVW);
        if (rec_ok) begin
          laps.push_back(val_pre);
          if (laps.size() > LAP_DEPTH) void'(laps.pop_front());
          m_total++;
          m_sel = laps.size() - 1;
        end else if (pulse[3] && n_laps > 0) begin
          m_sel = (m_sel + 1) % n_laps;
        end
        if (pulse[0]) m_state = (m_state == 1) ? 2 : 1;
        if (was_run) m_run++;
      end
    end
  end

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [7*NUM_DIG-1:0] exp_segs(input int v);
    logic [7*NUM_DIG-1:0] r;
    int pw;
    r  = '0;
    pw = 1;
    for (int k = 0; k < NUM_DIG; k++) begin
      r[7*k +: 7] = seg_of((v / pw) % 10);
      pw = pw * 10;
    end
    return r;
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    int cnt;
    int idx;
    cnt = laps.size();
    idx = (cnt == 0) ? 0 : ((m_total - cnt + m_sel) % LAP_DEPTH);
    checkValue("live",    live,    exp_segs((m_run / TICK_DIV) % MODV));
    checkValue("lap",     lap,     exp_segs(m_lap_disp));
    checkValue("lap_idx", lap_idx, idx);
    checkValue("lap_cnt", lap_cnt, cnt);
    checkValue("full",    full,    cnt == LAP_DEPTH);
    checkValue("ovf",     ovf,     (m_run / TICK_DIV) >= MODV);
    checkValue("state",   state,   m_state);
  endtask

  task automatic stepCycle();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic applyStimulus(input logic [3:0] mask, input int hold, input int gap);
    {f_recall, f_record, f_stop, f_start} = ~mask;
    repeat (hold) stepCycle();
    {f_recall, f_record, f_stop, f_start} = 4'hF;
    repeat (gap) stepCycle();
  endtask

  task automatic runUntil(input int target);
    int guard;
    guard = 0;
    while (m_run < target && guard < 2000) begin
      stepCycle();
      guard++;
    end
    checkValue("run_reach", m_run >= target, 1);
  endtask

  task automatic checkResetValues(input string tag);
    checkValue({tag, "_live"},  live,    exp_segs(0));
    checkValue({tag, "_lap"},   lap,     exp_segs(0));
    checkValue({tag, "_idx"},   lap_idx, 0);
    checkValue({tag, "_cnt"},   lap_cnt, 0);
    checkValue({tag, "_full"},  full,    0);
    checkValue({tag, "_ovf"},   ovf,     0);
    checkValue({tag, "_state"}, state,   2'b00);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] mask;
    $display("[TB] stopwatch_lap bench start (overwrite=%0d)", OVW);
    #1 rst = 1'b1;
    repeat (2) stepCycle();
    checkResetValues("reset");
    #2 rst = 1'b0;
    stepCycle();
    checkResetValues("post_reset");

    // Start latency and first ticks
    applyStimulus(B_START, 3, 1);
    checkValue("start_state", state, 2'b01);
    repeat (2) stepCycle();
    checkValue("live_pre_tick", live, exp_segs(0));
    stepCycle();
    checkValue("live_01", live, exp_segs(1));
    repeat (4) stepCycle();
    checkValue("live_02", live, exp_segs(2));

    // Wrap past 99 and clear on stop
    runUntil(99 * TICK_DIV);
    checkValue("live_99", live, exp_segs(99));
    checkValue("ovf_before", ovf, 0);
    repeat (TICK_DIV) stepCycle();
    checkValue("live_wrap", live, exp_segs(0));
    checkValue("ovf_set", ovf, 1);
    applyStimulus(B_STOP, 3, 1);
    checkValue("stop_state", state, 2'b00);
    checkValue("stop_ovf", ovf, 0);
    checkValue("stop_live", live, exp_segs(0));

    // Lap records at 07 (running) and 12 (paused)
    applyStimulus(B_START, 3, 1);
    runUntil(7 * TICK_DIV);
    applyStimulus(B_REC, 3, 1);
    checkValue("rec1_cnt", lap_cnt, 1);
    checkValue("rec1_lap", lap, exp_segs(7));
    runUntil(12 * TICK_DIV);
    applyStimulus(B_START, 3, 1);
    checkValue("pause_state", state, 2'b10);
    checkValue("pause_live", live, exp_segs(12));
    applyStimulus(B_REC, 3, 1);
    checkValue("rec2_cnt", lap_cnt, 2);
    checkValue("rec2_full", full, 1);
    checkValue("rec2_lap", lap, exp_segs(12));
    checkValue("rec2_idx", lap_idx, 1);
`ifdef LAP_OVERWRITE_EN
    applyStimulus(B_START, 3, 1);
    runUntil(20 * TICK_DIV);
    applyStimulus(B_REC, 3, 1);
    checkValue("ovw_cnt", lap_cnt, 2);
    checkValue("ovw_lap", lap, exp_segs(20));
    checkValue("ovw_idx", lap_idx, 0);
    applyStimulus(B_RECALL, 3, 1);
    checkValue("ovw_recall1", lap, exp_segs(12));
    applyStimulus(B_RECALL, 3, 1);
    checkValue("ovw_recall2", lap, exp_segs(20));
`else
    applyStimulus(B_REC, 3, 1);
    checkValue("rec3_cnt", lap_cnt, 2);
    checkValue("rec3_lap", lap, exp_segs(12));
    checkValue("rec3_idx", lap_idx, 1);
    applyStimulus(B_RECALL, 3, 1);
    checkValue("recall1_lap", lap, exp_segs(7));
    checkValue("recall1_idx", lap_idx, 0);
    applyStimulus(B_RECALL, 3, 1);
    checkValue("recall2_lap", lap, exp_segs(12));
    checkValue("recall2_idx", lap_idx, 1);
`endif
    applyStimulus(B_STOP, 3, 1);
    stepCycle();
    applyStimulus(B_RECALL, 3, 1);
    checkValue("empty_recall_idx", lap_idx, 0);
    checkValue("empty_recall_lap", lap, exp_segs(0));

    // Simultaneous presses
    applyStimulus(B_START, 3, 1);
    runUntil(2 * TICK_DIV);
    applyStimulus(B_REC, 3, 1);
    checkValue("pre_clear_cnt", lap_cnt, 1);
    applyStimulus(B_STOP | B_REC, 3, 1);
    checkValue("stop_rec_cnt", lap_cnt, 0);
    checkValue("stop_rec_state", state, 2'b00);
    applyStimulus(B_START, 3, 1);
    applyStimulus(B_START, 3, 1);
    checkValue("pause_again", state, 2'b10);
    applyStimulus(B_START | B_STOP, 3, 1);
    checkValue("start_stop_state", state, 2'b00);

    // Reset mid-run with start held low, released high
    applyStimulus(B_START, 3, 1);
    runUntil(5 * TICK_DIV);
    f_start = 1'b0;
    #2 rst = 1'b1;
    repeat (2) stepCycle();
    f_start = 1'b1;
    #2 rst = 1'b0;
    stepCycle();
    checkResetValues("mid_reset");
    repeat (6) stepCycle();
    checkValue("no_spurious_state", state, 2'b00);

    // Randomized button traffic checked every cycle
    for (int n = 0; n < 250; n++) begin
      mask = '0;
      if ($urandom_range(0, 2) == 0)  mask[0] = 1'b1;
      if ($urandom_range(0, 11) == 0) mask[1] = 1'b1;
      if ($urandom_range(0, 2) == 0)  mask[2] = 1'b1;
      if ($urandom_range(0, 2) == 0)  mask[3] = 1'b1;
      applyStimulus(mask, int'($urandom_range(1, 4)), int'($urandom_range(1, 6)));
      if ($urandom_range(0, 9) == 0) repeat ($urandom_range(10, 60)) stepCycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
